// File: rtl/count_rate_pkg.sv
// Shared types and helpers for the count rate meter.
package count_rate_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a counter that must reach window-1 (window >= 2).
  function automatic int win_cnt_width(input int window);
    return (window <= 2) ? 1 : $clog2(window);
  endfunction

endpackage

// File: rtl/count_rate_meter_if.sv
// Count input / rate result bundle for count_rate_meter.
// slave: the meter; master: whoever drives the count and reads the rate.
interface count_rate_meter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] count_i;
  logic             enable_i;
  logic [WIDTH-1:0] rate_o;
  logic             rate_valid_o;
  logic             overrange_o;
  logic             stall_o;

  modport slave (
    input  count_i, enable_i,
    output rate_o, rate_valid_o, overrange_o, stall_o
  );

  modport master (
    output count_i, enable_i,
    input  rate_o, rate_valid_o, overrange_o, stall_o
  );
endinterface

// File: rtl/count_rate_window_timer.sv
// Measurement window counter: counts 0..WINDOW-1 while enabled and wraps,
// flagging the last cycle of each window on tc_o.
import count_rate_pkg::*;

module count_rate_window_timer #(
  parameter int WINDOW = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = win_cnt_width(WINDOW);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  // Next count: clear wins, otherwise step and wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/count_rate_meter.sv
// count_rate_meter: samples a free-running count once per WINDOW clocks and
// reports the modular delta with a one-cycle valid strobe; deltas above
// MAX_DELTA (backward steps, jumps) raise overrange_o.
// Optional stall detection is built when COUNT_RATE_STALL_DETECT_EN is
// defined; otherwise stall_o is tied low.
import count_rate_pkg::*;

module count_rate_meter #(
  parameter int               WIDTH         = 32,
  parameter int               WINDOW        = 1000000,
  parameter logic [WIDTH-1:0] MAX_DELTA     = {1'b0, {(WIDTH-1){1'b1}}},
  parameter int               STALL_WINDOWS = 4
) (
  input logic               clk,
  input logic               rst,
  count_rate_meter_if.slave bus
);
  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rate_q;
  logic             valid_q;
  logic             over_q;
  logic [WIDTH-1:0] delta_d;
  logic             tc;

  // Unsigned modular difference: forward wraps come out small.
  assign delta_d = bus.count_i - prev_q;

  count_rate_window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .en_i  (state_q == RUN),
    .tc_o  (tc)
  );

  // Control FSM and registered rate outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      rate_q  <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.enable_i) begin
            prev_q  <= bus.count_i;
            state_q <= RUN;
          end
        end
        RUN: begin
          // A window ending on the same cycle enable drops is still reported.
          if (tc) begin
            prev_q  <= bus.count_i;
            rate_q  <= delta_d;
            valid_q <= 1'b1;
            over_q  <= (delta_d > MAX_DELTA);
          end
          if (!bus.enable_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rate_o       = rate_q;
  assign bus.rate_valid_o = valid_q;
  assign bus.overrange_o  = over_q;

`ifdef COUNT_RATE_STALL_DETECT_EN
  localparam int ZW = $clog2(STALL_WINDOWS + 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(STALL_WINDOWS);

  logic [ZW-1:0] zero_cnt_q;
  logic [ZW-1:0] zero_cnt_d;
  logic          stall_q;

  assign zero_cnt_d = (zero_cnt_q == ZMAX) ? zero_cnt_q : zero_cnt_q + ZW'(1);

  // Saturating run of zero-delta windows; leaving RUN clears it.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      zero_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (tc) begin
        if (delta_d == '0) begin
          zero_cnt_q <= zero_cnt_d;
          stall_q    <= (zero_cnt_d == ZMAX);
        end else begin
          zero_cnt_q <= '0;
          stall_q    <= 1'b0;
        end
      end
      if (!bus.enable_i) begin
        zero_cnt_q <= '0;
        stall_q    <= 1'b0;
      end
    end
  end

  assign bus.stall_o = stall_q;
`else
  assign bus.stall_o = 1'b0;
`endif
endmodule

// File: doc/count_rate_meter.md
Name: count_rate_meter

Overview:
Downstream consumer of a free-running counter value that has already been carried into the local clock domain by the cross-clock register stage. Samples the incoming count once per fixed window of local clocks and emits the per-window delta (a rate) with a one-cycle valid strobe. Flags implausible deltas (counter stepped backwards or jumped). Used for frequency, event-rate and throughput monitoring registers.

Parameters:
WIDTH, 32, width of the incoming count and of rate_o.
WINDOW, 1000000, measurement window length in clk cycles; must be >= 2.
MAX_DELTA, 2**(WIDTH-1)-1, largest delta accepted as valid; larger sets overrange_o.
STALL_WINDOWS, 4, consecutive zero-delta windows before stall_o asserts (used only with the optional feature).

Ports:
clk  in  1  local clock; one clock domain only.
rst  in  1  synchronous, active-high reset.
count_i  in  WIDTH  free-running count, already synchronous to clk; treated as coherent every cycle.
enable_i  in  1  run measurement; low holds the block idle.
rate_o  out  WIDTH  count delta over the last completed window.
rate_valid_o  out  1  one-cycle pulse when rate_o and overrange_o update.
overrange_o  out  1  delta of the window just reported exceeded MAX_DELTA.
stall_o  out  1  counter stalled (optional feature; else constant 0).

Behaviour:
- Reset (rst high at a clk edge): state IDLE; window counter 0; prev sample 0; rate_o 0; rate_valid_o 0; overrange_o 0; stall_o 0; zero-window counter 0. Reset overrides all other inputs, including mid-window.
- States: IDLE, RUN.
- IDLE: rate_valid_o 0; rate_o and overrange_o hold last values. If enable_i = 1: prev <= count_i, window counter <= 0, go to RUN.
- RUN: the window counter increments each cycle. When the counter = WINDOW-1, this is the boundary cycle: delta = (count_i - prev) mod 2**WIDTH; prev <= count_i; window counter <= 0. On the next cycle, rate_o = delta, overrange_o = (delta > MAX_DELTA), and rate_valid_o = 1 for exactly 1 cycle.
- Timing: with enable_i sampled high in IDLE at cycle E, the captures occur at E+WINDOW, E+2*WINDOW, and so on. rate_valid_o pulses at E+WINDOW+1, E+2*WINDOW+1, and so on.
- Wrap: unsigned modular subtraction. A forward wrap of the source counter gives the correct small delta. A backward step gives a huge delta, which raises overrange_o. rate_o still carries the raw delta.
- enable_i low in RUN: go to IDLE the next cycle. The partial window is discarded; no valid pulse is produced. If enable_i falls on the boundary cycle itself, that window's result is still reported.
- Re-enable always starts a fresh full window with a new prev capture.
- Window counter width is clog2(WINDOW); it must never exceed WINDOW-1.

Optional Feature:
Macro: COUNT_RATE_STALL_DETECT_EN.
- Defined: a zero-window counter (saturating at STALL_WINDOWS) increments on each reported delta of 0 and clears on any nonzero delta. stall_o is set in the same cycle as the rate_valid_o pulse that brings the count to STALL_WINDOWS. stall_o is cleared with the first nonzero-delta pulse. Going to IDLE clears the counter and stall_o.
- Undefined: no stall logic is built; stall_o is tied to 0.

Decomposition:
- Package count_rate_pkg: state enum typedef (IDLE, RUN); a function computing the window counter width from WINDOW.
- Sub-module count_rate_window_timer: window counter with clear and enable inputs, and a terminal-count output asserted at WINDOW-1. The top level holds the FSM, the delta datapath and the stall logic.

Test Plan:
- WINDOW=8; count_i +3 per clk; enable_i high from cycle 10 -> rate_valid_o pulses at cycles 19, 27, 35; rate_o=24 each time; overrange_o=0.
- Forward wrap: count_i starts at 0xFFFF_FFF0, +4 per clk, WINDOW=8 -> rate_o=32 on the pulse spanning the wrap; overrange_o=0.
- Backward step: count_i constant at 100, then 99 before the boundary -> rate_o=0xFFFF_FFFF; overrange_o=1 with the pulse; the next normal window gives overrange_o=0.
- enable_i dropped at window count 3 -> no pulse; rate_o holds its previous value (24). Re-enable at cycle R -> next pulse at R+9.
- rst asserted for 1 cycle mid-window -> next cycle all outputs 0 and state IDLE; with enable_i still high, the first pulse comes WINDOW+1 cycles after IDLE re-captures.
- With COUNT_RATE_STALL_DETECT_EN, STALL_WINDOWS=4, count_i constant -> stall_o rises with the 4th zero-delta pulse. Count then advances -> stall_o falls with the next pulse. Without the macro, stall_o stays 0.
